// File: rtl/aqalu_pkg.sv
// Shared AQALU constants and log-entry layout for the tick logger.
package aqalu_pkg;

  localparam int unsigned AQALU_DATA_W            = 8;
  localparam int unsigned AQALU_SEC_W             = 8;
  localparam int unsigned AQALU_TICK_CYCLES_10MHZ = 10_000_000;
  localparam int unsigned AQALU_LOG_DEPTH         = 4;

  // Log entry is {seconds, value}; value sits in the low bits.
  localparam int unsigned LOG_VALUE_LSB = 0;

  typedef struct packed {
    logic [AQALU_SEC_W-1:0]  seconds;
    logic [AQALU_DATA_W-1:0] value;
  } aqalu_log_entry_t;

  function automatic int unsigned log_seconds_lsb(input int unsigned data_w);
    return LOG_VALUE_LSB + data_w;
  endfunction

endpackage

// File: rtl/aqalu_tick_logger_if.sv
// ALU sample input and log drain port of the tick logger.
interface aqalu_tick_logger_if
  import aqalu_pkg::*;
#(
  parameter int unsigned DATA_W = AQALU_DATA_W,
  parameter int unsigned SEC_W  = AQALU_SEC_W
);

  logic [DATA_W-1:0]       alu_out;
  logic                    capture_on_change;
  logic                    log_valid;
  logic                    log_ready;
  logic [SEC_W+DATA_W-1:0] log_data;
  logic [SEC_W-1:0]        seconds;
  logic                    tick;
  logic                    overflow;

  modport master (
    output alu_out, capture_on_change, log_ready,
    input  log_valid, log_data, seconds, tick, overflow
  );

  modport slave (
    input  alu_out, capture_on_change, log_ready,
    output log_valid, log_data, seconds, tick, overflow
  );

endinterface

// File: rtl/aqalu_log_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only alongside a pop.
module aqalu_log_fifo
  import aqalu_pkg::*;
#(
  parameter int unsigned DEPTH = AQALU_LOG_DEPTH,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] rdata,
  output logic             drop
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  always_comb begin
    empty     = (r_count == '0);
    full      = (r_count == CNT_W'(DEPTH));
    w_do_pop  = pop && !empty;
    w_do_push = push && (!full || w_do_pop);
    drop      = push && !w_do_push;
    rdata     = r_mem[r_rd_ptr];
  end

  // Storage; when full the write slot equals the head being popped this cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/aqalu_tick_logger.sv
// Seconds timebase plus capture of the AQALU result into a tagged log FIFO.
module aqalu_tick_logger
  import aqalu_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = AQALU_TICK_CYCLES_10MHZ,
  parameter int unsigned DEPTH       = AQALU_LOG_DEPTH,
  parameter int unsigned SEC_W       = AQALU_SEC_W,
  parameter int unsigned DATA_W      = AQALU_DATA_W
) (
  input  logic                 clock,
  input  logic                 reset,
  aqalu_tick_logger_if.slave   bus
);

  localparam int unsigned CNT_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned ENTRY_W = SEC_W + DATA_W;
  localparam int unsigned SEC_LSB = log_seconds_lsb(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic               r_tick;
  logic [SEC_W-1:0]   r_seconds;
  logic [DATA_W-1:0]  r_prev_out;
  logic               r_overflow;

  logic               w_tick;
  logic               w_change;
  logic               w_capture;
  logic [SEC_W-1:0]   w_sec_next;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_head;

  // Capture arbitration: tick and change collapse into a single push.
  always_comb begin
    w_tick     = (r_cnt == CNT_LAST);
    w_change   = bus.capture_on_change && (bus.alu_out != r_prev_out);
    w_capture  = w_tick || w_change;
    w_sec_next = w_tick ? (r_seconds + SEC_W'(1)) : r_seconds;
    w_entry    = '0;
    w_entry[LOG_VALUE_LSB +: DATA_W] = bus.alu_out;
    w_entry[SEC_LSB +: SEC_W]        = w_sec_next;
    w_pop      = !w_empty && bus.log_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_seconds <= '0;
    end else begin
      r_cnt     <= w_tick ? '0 : (r_cnt + CNT_W'(1));
      r_tick    <= w_tick;
      r_seconds <= w_sec_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev_out <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_out <= bus.alu_out;
      r_overflow <= r_overflow || w_drop;
    end
  end

  aqalu_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_capture),
    .wdata (w_entry),
    .full  (w_full),
    .pop   (w_pop),
    .empty (w_empty),
    .rdata (w_head),
    .drop  (w_drop)
  );

  // A drop can only come from a full FIFO.
  a_drop_only_when_full : assert property (@(posedge clock) disable iff (reset) w_drop |-> w_full);

  assign bus.tick      = r_tick;
  assign bus.seconds   = r_seconds;
  assign bus.overflow  = r_overflow;
  assign bus.log_valid = !w_empty;
  assign bus.log_data  = w_head;

endmodule
